// File: rtl/host_axi_mem_responder.sv
// rtl/host_axi_mem_responder.sv - AXI4 responder backed by an internal word-addressed RAM
// Optional macro AXI_MEM_BACKPRESSURE_EN: LFSR-driven ready throttling and valid insertion delay.
module host_axi_mem_responder #(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             wr_burst_cnt,
  output logic [31:0]             rd_burst_cnt
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = MEM_DEPTH_LOG2;
  localparam int DEPTH    = 1 << MEM_DEPTH_LOG2;
  localparam logic [2:0]       SIZE_FULL   = 3'(ADDR_LSB);
  localparam logic [1:0]       BURST_FIXED = 2'b00;
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic rdy_ok, b_gate, r_gate;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        vld_hold, b_shown_q, r_shown_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= 16'hACE1;
      b_shown_q <= 1'b0;
      r_shown_q <= 1'b0;
    end else begin
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      b_shown_q <= s_axi_bvalid & ~s_axi_bready;
      r_shown_q <= s_axi_rvalid & ~s_axi_rready;
    end
  end

  // Once a valid has been shown it stays up until accepted, whatever the LFSR says.
  assign rdy_ok   = (lfsr_q[1:0] != 2'b00);
  assign vld_hold = (lfsr_q[3:2] == 2'b00);
  assign b_gate   = b_shown_q | ~vld_hold;
  assign r_gate   = r_shown_q | ~vld_hold;
`else
  assign rdy_ok = 1'b1;
  assign b_gate = 1'b1;
  assign r_gate = 1'b1;
`endif

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic              w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic              w_at_last;

  assign s_axi_awready = (w_state_q == W_IDLE) & rdy_ok & ~rst;
  assign s_axi_wready  = (w_state_q == W_DATA) & rdy_ok & ~rst;
  assign s_axi_bvalid  = (w_state_q == W_RESP) & b_gate;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign wr_burst_cnt  = wr_cnt_q;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign b_hs      = s_axi_bvalid & s_axi_bready;
  assign w_at_last = (w_beat_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_idx_d   = w_idx_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    wr_cnt_d  = wr_cnt_q;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_id_d    = s_axi_awid;
        w_len_d   = s_axi_awlen;
        w_beat_d  = 8'd0;
        w_idx_d   = s_axi_awaddr[ADDR_LSB +: IDX_W];
        w_fixed_d = (s_axi_awburst == BURST_FIXED);
        w_err_d   = (s_axi_awsize != SIZE_FULL);
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        // The burst always runs len+1 beats; a misplaced wlast only flags the response.
        if (s_axi_wlast != w_at_last) w_err_d = 1'b1;
        if (w_at_last) begin
          w_state_d = W_RESP;
        end else begin
          w_beat_d = w_beat_q + 8'd1;
          if (!w_fixed_q) w_idx_d = w_idx_q + IDX_ONE;
        end
      end
      W_RESP: if (b_hs) begin
        wr_cnt_d  = wr_cnt_q + 32'd1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_idx_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_idx_q   <= w_idx_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  // RAM read register feeds a 2-entry output queue; issue is credit-limited so the
  // queue never overflows and streams one beat per cycle when rready stays high.
  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [7:0]          r_len_q, r_len_d;
  logic [8:0]          r_issued_q, r_issued_d;
  logic [IDX_W-1:0]    r_idx_q, r_idx_d, issue_idx, ar_idx;
  logic                r_fixed_q, r_fixed_d, r_err_q, r_err_d;
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic                r_issue, issue_last, r_space;
  logic [2:0]          r_occ;

  logic [DATA_WIDTH-1:0] ram_data_q;
  logic                  ram_vld_q, ram_last_q;
  logic [DATA_WIDTH-1:0] f_data_q [2];
  logic                  f_last_q [2];
  logic                  f_wptr_q, f_rptr_q;
  logic [1:0]            f_cnt_q;
  logic                  f_nonempty;

  assign f_nonempty    = (f_cnt_q != 2'd0);
  assign s_axi_arready = (r_state_q == R_IDLE) & rdy_ok & ~rst;
  assign s_axi_rvalid  = f_nonempty & r_gate;
  assign s_axi_rdata   = f_data_q[f_rptr_q];
  assign s_axi_rlast   = f_nonempty & f_last_q[f_rptr_q];
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign rd_burst_cnt  = rd_cnt_q;

  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign ar_idx  = s_axi_araddr[ADDR_LSB +: IDX_W];
  assign r_occ   = {1'b0, f_cnt_q} + {2'b00, ram_vld_q};
  assign r_space = ((r_occ - {2'b00, r_hs}) < 3'd2);

  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_len_d    = r_len_q;
    r_issued_d = r_issued_q;
    r_idx_d    = r_idx_q;
    r_fixed_d  = r_fixed_q;
    r_err_d    = r_err_q;
    rd_cnt_d   = rd_cnt_q;
    r_issue    = 1'b0;
    issue_idx  = r_idx_q;
    issue_last = (r_issued_q == {1'b0, r_len_q});
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        // First beat is read in the handshake cycle to give the 2-cycle AR-to-R latency.
        r_id_d     = s_axi_arid;
        r_len_d    = s_axi_arlen;
        r_fixed_d  = (s_axi_arburst == BURST_FIXED);
        r_err_d    = (s_axi_arsize != SIZE_FULL);
        r_issue    = 1'b1;
        issue_idx  = ar_idx;
        issue_last = (s_axi_arlen == 8'd0);
        r_idx_d    = (s_axi_arburst == BURST_FIXED) ? ar_idx : ar_idx + IDX_ONE;
        r_issued_d = 9'd1;
        r_state_d  = R_DATA;
      end
      R_DATA: begin
        if ((r_issued_q <= {1'b0, r_len_q}) && r_space) begin
          r_issue    = 1'b1;
          r_issued_d = r_issued_q + 9'd1;
          if (!r_fixed_q) r_idx_d = r_idx_q + IDX_ONE;
        end
        if (r_hs && s_axi_rlast) begin
          rd_cnt_d  = rd_cnt_q + 32'd1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_len_q    <= '0;
      r_issued_q <= '0;
      r_idx_q    <= '0;
      r_fixed_q  <= 1'b0;
      r_err_q    <= 1'b0;
      rd_cnt_q   <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      f_wptr_q   <= 1'b0;
      f_rptr_q   <= 1'b0;
      f_cnt_q    <= 2'd0;
      f_last_q   <= '{1'b0, 1'b0};
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_len_q    <= r_len_d;
      r_issued_q <= r_issued_d;
      r_idx_q    <= r_idx_d;
      r_fixed_q  <= r_fixed_d;
      r_err_q    <= r_err_d;
      rd_cnt_q   <= rd_cnt_d;
      ram_vld_q  <= r_issue;
      if (r_issue) ram_last_q <= issue_last;
      if (ram_vld_q) begin
        f_last_q[f_wptr_q] <= ram_last_q;
        f_wptr_q           <= ~f_wptr_q;
      end
      if (r_hs) f_rptr_q <= ~f_rptr_q;
      f_cnt_q <= f_cnt_q + {1'b0, ram_vld_q} - {1'b0, r_hs};
    end
  end

  // Read-first: the nonblocking RAM read sees the word before a same-cycle write lands.
  always_ff @(posedge clk) begin
    if (r_issue) ram_data_q <= mem_q[issue_idx];
    if (ram_vld_q) f_data_q[f_wptr_q] <= ram_data_q;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

endmodule

// File: tb/tb_host_axi_mem_responder.sv
// tb/tb_host_axi_mem_responder.sv - randomized self-checking bench against a behavioural memory model
module tb_host_axi_mem_responder;
  localparam int IDW = 4, AW = 32, DW = 512, MDL = 12;
  localparam int SW = DW / 8, LSB = 6, DEPTH = 1 << MDL;

  logic clk = 1'b0, rst;
  logic [IDW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [AW-1:0]  s_axi_awaddr, s_axi_araddr;
  logic [7:0]     s_axi_awlen, s_axi_arlen;
  logic [2:0]     s_axi_awsize, s_axi_arsize;
  logic [1:0]     s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic           s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic           s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic           s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0]  s_axi_wdata, s_axi_rdata;
  logic [SW-1:0]  s_axi_wstrb;
  logic [31:0]    wr_burst_cnt, rd_burst_cnt;

  host_axi_mem_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(MDL)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mdl [DEPTH];
  int mdl_wr = 0, mdl_rd = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [SW-1:0] rand_strb();
    logic [SW-1:0] s;
    for (int k = 0; k < SW / 32; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  // last_at = beat index carrying wlast (len for a well-formed burst, len+1 for none)
  task automatic do_write(input logic [AW-1:0] addr, input logic [1:0] burst, input logic [2:0] size,
                          input int last_at, input logic [IDW-1:0] id,
                          input logic [DW-1:0] dq[$], input logic [SW-1:0] sq[$]);
    int len, idx, t;
    logic [1:0] exp_resp;
    len = dq.size() - 1;
    idx = int'((addr >> LSB) % DEPTH);
    exp_resp = (size != 3'(LSB) || last_at != len) ? 2'b10 : 2'b00;
    @(negedge clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("aw_timeout", 0, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wdata = dq[i]; s_axi_wstrb = sq[i]; s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("w_timeout", 0, 1);
      for (int b = 0; b < SW; b++) if (sq[i][b]) mdl[idx][b*8 +: 8] = dq[i][b*8 +: 8];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("b_timeout", 0, 1);
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, exp_resp);
    @(negedge clk);
    s_axi_bready = 1'b0;
    mdl_wr++;
    check("wr_burst_cnt", wr_burst_cnt, mdl_wr);
  endtask

  // mode 0: rready always 1; 1: pattern 1,0,0 repeating; 2: random
  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [IDW-1:0] id, input int mode,
                         input bit chk_timing);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] held;
    logic [1:0] exp_resp;
    int idx, t, got_n, h, last_c;
    bit stalled, seen;
    idx = int'((addr >> LSB) % DEPTH);
    for (int i = 0; i <= len; i++) begin
      expq.push_back(mdl[idx]);
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    exp_resp = (size != 3'(LSB)) ? 2'b10 : 2'b00;
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("ar_timeout", 0, 1);
    h = cyc;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    got_n = 0; t = 0; stalled = 0; seen = 0; last_c = 0; held = '0;
    while (got_n <= len && t < 3000) begin
      case (mode)
        0: s_axi_rready = 1'b1;
        1: s_axi_rready = (t % 3 == 0);
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check("r_stall_valid", s_axi_rvalid, 1);
        check("r_stall_data", s_axi_rdata, held);
      end
      stalled = 0;
      if (s_axi_rvalid) begin
        if (!seen && chk_timing) check("r_first_latency", cyc - h, 2);
        seen = 1;
        if (s_axi_rready) begin
          check("rdata", s_axi_rdata, expq[got_n]);
          check("rlast", s_axi_rlast, (got_n == len));
          check("rresp", s_axi_rresp, exp_resp);
          check("rid", s_axi_rid, id);
          if (chk_timing && got_n > 0) check("r_beat_gap", cyc - last_c, 1);
          last_c = cyc;
          got_n++;
        end else begin
          stalled = 1;
          held = s_axi_rdata;
        end
      end
      @(negedge clk);
      t++;
    end
    s_axi_rready = 1'b0;
    if (got_n <= len) check("r_timeout", got_n, len + 1);
    check("r_idle_after_last", s_axi_rvalid, 0);
    mdl_rd++;
    check("rd_burst_cnt", rd_burst_cnt, mdl_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] dq[$];
    logic [SW-1:0] sq[$];
    logic [AW-1:0] a;
    logic [1:0]    bt;
    logic [2:0]    sz;
    int len, last_at, n, t;

    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_wr_cnt", wr_burst_cnt, 0);
    check("rst_rd_cnt", rd_burst_cnt, 0);
    rst = 1'b0;

    // Fill the whole RAM with 256-beat INCR bursts so every later read is defined.
    for (int blk = 0; blk < DEPTH / 256; blk++) begin
      dq.delete(); sq.delete();
      for (int i = 0; i < 256; i++) begin dq.push_back(rand_word()); sq.push_back('1); end
      do_write(AW'(blk * 256 * SW), 2'b01, 3'(LSB), 255, 4'(blk), dq, sq);
    end
    do_read(32'h0000_8000, 255, 2'b01, 3'(LSB), 4'h3, 2, 0);

    // INCR 16 beats at 0x1000, data = beat index, then streaming readback
    dq.delete(); sq.delete();
    for (int i = 0; i < 16; i++) begin dq.push_back(DW'(i)); sq.push_back('1); end
    do_write(32'h1000, 2'b01, 3'(LSB), 15, 4'h1, dq, sq);
    do_read(32'h1000, 15, 2'b01, 3'(LSB), 4'h2, 0, 1);

    // Early wlast on beat 1 of a 4-beat burst
    dq.delete(); sq.delete();
    for (int i = 0; i < 4; i++) begin dq.push_back(rand_word()); sq.push_back('1); end
    do_write(32'h3000, 2'b01, 3'(LSB), 1, 4'h5, dq, sq);
    do_read(32'h3000, 3, 2'b01, 3'(LSB), 4'h5, 0, 0);

    // Partial strobe over all-ones word
    dq.delete(); sq.delete();
    dq.push_back('1); sq.push_back('1);
    do_write(32'h40, 2'b01, 3'(LSB), 0, 4'h6, dq, sq);
    dq.delete(); sq.delete();
    dq.push_back(DW'(64'h0000_0000_1234_5678)); sq.push_back(SW'(4'hF));
    do_write(32'h40, 2'b01, 3'(LSB), 0, 4'h6, dq, sq);
    do_read(32'h40, 0, 2'b01, 3'(LSB), 4'h6, 0, 0);
    check("strobe_merge", mdl[1], {{(DW-32){1'b1}}, 32'h1234_5678});

    // 8-beat read with rready 1,0,0 pattern
    do_read(32'h1000, 7, 2'b01, 3'(LSB), 4'h7, 1, 0);

    // Concurrent AW and AR to the same word
    dq.delete(); sq.delete();
    dq.push_back(DW'(8'hA5)); sq.push_back('1);
    do_write(32'h2000, 2'b01, 3'(LSB), 0, 4'h8, dq, sq);
    dq.delete(); sq.delete();
    dq.push_back(DW'(8'h5A)); sq.push_back('1);
    fork
      do_write(32'h2000, 2'b01, 3'(LSB), 0, 4'h9, dq, sq);
      do_read(32'h2000, 0, 2'b01, 3'(LSB), 4'hA, 0, 1);
    join
    do_read(32'h2000, 0, 2'b01, 3'(LSB), 4'hB, 0, 0);

    // Randomized bursts: type, size, length, strobes, wlast placement, rready
    for (int it = 0; it < 30; it++) begin
      a = $urandom;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
      bt = 2'($urandom_range(0, 2));
      sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 5)) : 3'(LSB);
      last_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
      dq.delete(); sq.delete();
      for (int i = 0; i <= len; i++) begin dq.push_back(rand_word()); sq.push_back(rand_strb()); end
      do_write(a, bt, sz, last_at, 4'($urandom), dq, sq);
      do_read(a, len, bt, sz, 4'($urandom), 2, 0);
      do_read($urandom, $urandom_range(0, 15), 2'($urandom_range(0, 2)), 3'(LSB), 4'($urandom),
              $urandom_range(0, 2), 0);
    end

    // Reset during beat 5 of a 16-beat read
    @(negedge clk);
    s_axi_arid = 4'hC; s_axi_araddr = 32'h1000; s_axi_arlen = 8'd15;
    s_axi_arsize = 3'(LSB); s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("rst_ar_timeout", 0, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    n = 0; t = 0;
    while (n < 5 && t < 200) begin
      if (s_axi_rvalid) n++;
      @(negedge clk);
      t++;
    end
    check("rst_pre_beats", n, 5);
    check("rst_beat5_valid", s_axi_rvalid, 1);
    s_axi_rready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", s_axi_rvalid, 0);
    check("midrst_arready", s_axi_arready, 0);
    check("midrst_rd_cnt", rd_burst_cnt, 0);
    check("midrst_wr_cnt", wr_burst_cnt, 0);
    rst = 1'b0;
    mdl_rd = 0; mdl_wr = 0;
    @(negedge clk);
    check("postrst_rvalid", s_axi_rvalid, 0);
    check("postrst_arready", s_axi_arready, 1);
    do_read(32'h1000, 15, 2'b01, 3'(LSB), 4'hD, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
